// File: rtl/serial_sub16_if.sv
// Start/Busy/Done handshake and operand/result bundle for the bit-serial subtractor.
// The requester drives through the master modport and the subtractor answers on the slave side.
interface serial_sub16_if #(
  parameter int WIDTH = 16
);
  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] R;
  logic             Co;
  logic             Ovf;
  logic             Zero;

  modport master (
    output Start, A, B,
    input  Busy, Done, R, Co, Ovf, Zero
  );

  modport slave (
    input  Start, A, B,
    output Busy, Done, R, Co, Ovf, Zero
  );
endinterface

// File: rtl/serial_sub16.sv
// Bit-serial two's-complement subtractor: one full-adder cell iterated WIDTH times
// on A + ~B + 1 with a registered carry, then result and flags are published together.
module serial_sub16 #(
  parameter int WIDTH = 16
) (
  input  logic          CLK,
  input  logic          Reset_n,
  serial_sub16_if.slave bus
);

  localparam int CNT_W = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MSB_IN = CNT_W'(WIDTH - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             carry;
  logic             cmsb;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] r_q;
  logic             co_q;
  logic             ovf_q;
  logic             zero_q;

  logic             busy;
  logic             done;

  logic             accept;
  logic             run;
  logic             last_step;
  logic             sum_bit;
  logic             carry_nxt;
  logic [WIDTH-1:0] sr_nxt;

  function automatic logic majority(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  assign accept    = (state == S_IDLE) && bus.Start;
  assign run       = (state == S_RUN);
  assign last_step = run && (cnt == CNT_LAST);

  // Single full-adder cell working on the LSBs of the operand shift registers.
  assign sum_bit   = sa[0] ^ sb[0] ^ carry;
  assign carry_nxt = majority(sa[0], sb[0], carry);
  assign sr_nxt    = {sum_bit, sr[WIDTH-1:1]};

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (bus.Start) state_nxt = S_RUN;
      S_RUN:   if (cnt == CNT_LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      S_RUN:   busy = 1'b1;
      S_DONE:  begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Serial datapath: operands load on accept, then shift one bit per RUN cycle.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      carry <= 1'b0;
      cmsb  <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      sa    <= bus.A;
      sb    <= ~bus.B;
      carry <= 1'b1;
      cnt   <= '0;
    end else if (run) begin
      sa    <= {1'b0, sa[WIDTH-1:1]};
      sb    <= {1'b0, sb[WIDTH-1:1]};
      sr    <= sr_nxt;
      carry <= carry_nxt;
      cnt   <= cnt + 1'b1;
      if (cnt == CNT_MSB_IN) begin
        cmsb <= carry_nxt;
      end
    end
  end

  // Result and flags change only on the MSB step, so RUN never exposes partial sums.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_q    <= '0;
      co_q   <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (last_step) begin
      r_q    <= sr_nxt;
      co_q   <= carry_nxt;
      ovf_q  <= cmsb ^ carry_nxt;
      zero_q <= (sr_nxt == '0);
    end
  end

  assign bus.Busy = busy;
  assign bus.Done = done;
  assign bus.R    = r_q;
  assign bus.Co   = co_q;
  assign bus.Ovf  = ovf_q;
  assign bus.Zero = zero_q;

endmodule

// File: tb/tb_serial_sub16.sv
// Randomized scoreboard bench for serial_sub16: stimulus pushes arithmetic expectations,
// a negedge monitor pops them on every Done and also watches latency and output stability.
module tb_serial_sub16;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] r;
    logic         co;
    logic         ovf;
    logic         zero;
    int           acc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  exp_t q[$];

  logic [W-1:0] last_r;
  logic         last_co;
  logic         last_ovf;
  logic         last_zero;

  serial_sub16_if #(.WIDTH(W)) bus ();

  serial_sub16 #(.WIDTH(W)) dut (
    .CLK     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer subtraction, unsigned and signed views.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
    exp_t e;
    int   d;
    int   sd;
    d      = int'(a) - int'(b);
    sd     = int'($signed(a)) - int'($signed(b));
    e.r    = W'(d & ((1 << W) - 1));
    e.co   = (a >= b);
    e.ovf  = (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));
    e.zero = (e.r == '0);
    e.acc  = acc;
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      last_r    = '0;
      last_co   = 1'b0;
      last_ovf  = 1'b0;
      last_zero = 1'b0;
    end else if (bus.Done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=Done required=no_Done (t=%0t)", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result_R", 32'(bus.R), 32'(e.r));
        chk("flag_Co", 32'(bus.Co), 32'(e.co));
        chk("flag_Ovf", 32'(bus.Ovf), 32'(e.ovf));
        chk("flag_Zero", 32'(bus.Zero), 32'(e.zero));
        chk("done_latency", 32'(cyc - e.acc), 32'(W));
        chk("busy_in_done", 32'(bus.Busy), 32'd1);
      end
      last_r    = bus.R;
      last_co   = bus.Co;
      last_ovf  = bus.Ovf;
      last_zero = bus.Zero;
    end else begin
      chk("outputs_hold", {12'd0, bus.R, bus.Co, bus.Ovf, bus.Zero},
          {12'd0, last_r, last_co, last_ovf, last_zero});
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.Busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (bus.Busy) chk("wait_idle_timeout", 32'(bus.Busy), 32'd0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.Done && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!bus.Done) chk("wait_done_timeout", 32'(bus.Done), 32'd1);
  endtask

  // Issues one op starting from an IDLE negedge; returns 1ns after the accepting edge.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
    wait_idle();
    bus.Start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    #1;
    q.push_back(model(a, b, cyc));
    bus.Start = 1'b0;
    bus.A     = W'($urandom);
    bus.B     = W'($urandom);
  endtask

  initial begin
    int acc1;
    int n;
    logic [W-1:0] a;
    logic [W-1:0] b;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.Start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_Busy", 32'(bus.Busy), 32'd0);
    chk("reset_Done", 32'(bus.Done), 32'd0);
    chk("reset_R", 32'(bus.R), 32'd0);
    chk("reset_flags", {29'd0, bus.Co, bus.Ovf, bus.Zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(16'd5, 16'd3);
    do_op(16'd3, 16'd5);
    do_op(16'h8000, 16'h0001);
    do_op(16'h7FFF, 16'hFFFF);
    do_op(16'h1234, 16'h1234);
    do_op(16'h0000, 16'h0000);

    // Start during RUN and in the DONE cycle must be ignored.
    do_op(16'h4321, 16'h0123);
    repeat (5) @(posedge clk);
    #1;
    bus.Start = 1'b1;
    bus.A     = 16'hFFFF;
    bus.B     = 16'h0001;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    wait_done();
    bus.Start = 1'b1;
    bus.A     = 16'h0AAA;
    bus.B     = 16'h0555;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    @(negedge clk);
    chk("ignored_start_busy0", 32'(bus.Busy), 32'd0);
    @(negedge clk);
    chk("ignored_start_busy1", 32'(bus.Busy), 32'd0);

    // Start held high: back-to-back accepts 18 edges apart.
    wait_idle();
    bus.Start = 1'b1;
    bus.A     = 16'h00F0;
    bus.B     = 16'h0F00;
    @(posedge clk);
    #1;
    acc1 = cyc;
    q.push_back(model(16'h00F0, 16'h0F00, cyc));
    bus.A = 16'hC000;
    bus.B = 16'h4000;
    wait_done();
    @(posedge clk);
    #1;
    chk("held_start_idle_gap", 32'(bus.Busy), 32'd0);
    @(posedge clk);
    #1;
    chk("held_start_reaccept", 32'(bus.Busy), 32'd1);
    chk("held_start_spacing", 32'(cyc - acc1), 32'd18);
    q.push_back(model(16'hC000, 16'h4000, cyc));
    bus.Start = 1'b0;

    // Asynchronous reset in the middle of RUN aborts the op.
    do_op(16'hBEEF, 16'h1111);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_Busy", 32'(bus.Busy), 32'd0);
    chk("abort_Done", 32'(bus.Done), 32'd0);
    chk("abort_outputs", {12'd0, bus.R, bus.Co, bus.Ovf, bus.Zero}, 32'd0);
    q.delete();
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'd9, 16'd4);

    for (int i = 0; i < 30; i++) begin
      a = pick();
      b = ($urandom_range(0, 5) == 0) ? a : pick();
      do_op(a, b);
    end

    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
